// File: rtl/onehot_span_decoder.sv
// Two-stage decoder for leftmost/rightmost one-hot vectors: binary indices, span,
// malformed-word flag and saturating word/error counters.
module onehot_span_decoder #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_left_i,
  input  logic [WIDTH-1:0] data_right_i,
  input  logic             data_val_i,
  input  logic             clr_cnt_i,
  output logic [IDX_W-1:0] left_idx_o,
  output logic [IDX_W-1:0] right_idx_o,
  output logic [IDX_W:0]   span_o,
  output logic             data_val_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  // Positions whose binary index has bit b set; OR-ing the masked vector yields index bit b.
  function automatic logic [WIDTH-1:0] idx_bit_mask(input int b);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = ((i >> b) & 1) != 0;
    end
    return m;
  endfunction

  logic [IDX_W-1:0] left_bin;
  logic [IDX_W-1:0] right_bin;

  for (genvar gi = 0; gi < IDX_W; gi++) begin : g_bin
    localparam logic [WIDTH-1:0] BIT_MASK = idx_bit_mask(gi);
    assign left_bin[gi]  = |(data_left_i & BIT_MASK);
    assign right_bin[gi] = |(data_right_i & BIT_MASK);
  end

  logic left_zero, left_multi, left_onehot;
  logic right_zero, right_multi, right_onehot;

  // v & (v-1) clears the lowest set bit; anything left over means more than one bit.
  assign left_zero    = ~|data_left_i;
  assign left_multi   = |(data_left_i & (data_left_i - WIDTH'(1)));
  assign left_onehot  = ~left_zero & ~left_multi;
  assign right_zero   = ~|data_right_i;
  assign right_multi  = |(data_right_i & (data_right_i - WIDTH'(1)));
  assign right_onehot = ~right_zero & ~right_multi;

  logic             s1_val_reg;
  logic [IDX_W-1:0] s1_left_idx_reg;
  logic [IDX_W-1:0] s1_right_idx_reg;
  logic             s1_left_zero_reg, s1_left_multi_reg, s1_left_onehot_reg;
  logic             s1_right_zero_reg, s1_right_multi_reg, s1_right_onehot_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_val_reg          <= 1'b0;
      s1_left_idx_reg     <= '0;
      s1_right_idx_reg    <= '0;
      s1_left_zero_reg    <= 1'b0;
      s1_left_multi_reg   <= 1'b0;
      s1_left_onehot_reg  <= 1'b0;
      s1_right_zero_reg   <= 1'b0;
      s1_right_multi_reg  <= 1'b0;
      s1_right_onehot_reg <= 1'b0;
    end else begin
      s1_val_reg <= data_val_i;
      if (data_val_i) begin
        s1_left_idx_reg     <= left_bin;
        s1_right_idx_reg    <= right_bin;
        s1_left_zero_reg    <= left_zero;
        s1_left_multi_reg   <= left_multi;
        s1_left_onehot_reg  <= left_onehot;
        s1_right_zero_reg   <= right_zero;
        s1_right_multi_reg  <= right_multi;
        s1_right_onehot_reg <= right_onehot;
      end
    end
  end

  logic             word_err;
  logic             word_normal;
  logic [IDX_W-1:0] left_idx_next;
  logic [IDX_W-1:0] right_idx_next;
  logic [IDX_W:0]   span_next;
  logic [CNT_W-1:0] word_cnt_next;
  logic [CNT_W-1:0] err_cnt_next;

  logic             data_val_reg;
  logic             err_reg;
  logic [IDX_W-1:0] left_idx_reg;
  logic [IDX_W-1:0] right_idx_reg;
  logic [IDX_W:0]   span_reg;
  logic [CNT_W-1:0] word_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  always_comb begin
    word_err = s1_left_multi_reg | s1_right_multi_reg
             | (s1_left_zero_reg ^ s1_right_zero_reg)
             | (s1_left_onehot_reg & s1_right_onehot_reg
                & (s1_left_idx_reg < s1_right_idx_reg));
    word_normal    = s1_left_onehot_reg & s1_right_onehot_reg & ~word_err;
    left_idx_next  = '0;
    right_idx_next = '0;
    span_next      = '0;
    if (word_normal) begin
      left_idx_next  = s1_left_idx_reg;
      right_idx_next = s1_right_idx_reg;
      span_next      = {1'b0, s1_left_idx_reg} - {1'b0, s1_right_idx_reg} + (IDX_W+1)'(1);
    end
  end

  // Counters move on the edge that presents the word; a coincident clear takes priority.
  always_comb begin
    word_cnt_next = word_cnt_reg;
    err_cnt_next  = err_cnt_reg;
    if (clr_cnt_i) begin
      word_cnt_next = '0;
      err_cnt_next  = '0;
    end else if (s1_val_reg) begin
      if (word_cnt_reg != '1) word_cnt_next = word_cnt_reg + CNT_W'(1);
      if (word_err && err_cnt_reg != '1) err_cnt_next = err_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_val_reg  <= 1'b0;
      err_reg       <= 1'b0;
      left_idx_reg  <= '0;
      right_idx_reg <= '0;
      span_reg      <= '0;
      word_cnt_reg  <= '0;
      err_cnt_reg   <= '0;
    end else begin
      data_val_reg <= s1_val_reg;
      word_cnt_reg <= word_cnt_next;
      err_cnt_reg  <= err_cnt_next;
      if (s1_val_reg) begin
        err_reg       <= word_err;
        left_idx_reg  <= left_idx_next;
        right_idx_reg <= right_idx_next;
        span_reg      <= span_next;
      end
    end
  end

  assign data_val_o  = data_val_reg;
  assign err_o       = err_reg;
  assign left_idx_o  = left_idx_reg;
  assign right_idx_o = right_idx_reg;
  assign span_o      = span_reg;
  assign word_cnt_o  = word_cnt_reg;
  assign err_cnt_o   = err_cnt_reg;

endmodule

// File: tb/tb_onehot_span_decoder.sv
// Scoreboard bench for onehot_span_decoder: a 16-bit-counter instance and a
// 4-bit-counter instance share stimulus; results are checked against a reference model.
module tb_onehot_span_decoder;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [15:0] data_left_i;
  logic [15:0] data_right_i;
  logic        data_val_i;
  logic        clr_cnt_i;

  logic [3:0]  left_idx_o, right_idx_o;
  logic [4:0]  span_o;
  logic        data_val_o, err_o;
  logic [15:0] word_cnt_o, err_cnt_o;

  logic [3:0]  sat_left_idx_o, sat_right_idx_o;
  logic [4:0]  sat_span_o;
  logic        sat_data_val_o, sat_err_o;
  logic [3:0]  sat_word_cnt_o, sat_err_cnt_o;

  always #5 clk_i = ~clk_i;

  onehot_span_decoder #(.WIDTH(16), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .data_left_i(data_left_i), .data_right_i(data_right_i),
    .data_val_i(data_val_i), .clr_cnt_i(clr_cnt_i),
    .left_idx_o(left_idx_o), .right_idx_o(right_idx_o), .span_o(span_o),
    .data_val_o(data_val_o), .err_o(err_o),
    .word_cnt_o(word_cnt_o), .err_cnt_o(err_cnt_o)
  );

  onehot_span_decoder #(.WIDTH(16), .CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .data_left_i(data_left_i), .data_right_i(data_right_i),
    .data_val_i(data_val_i), .clr_cnt_i(clr_cnt_i),
    .left_idx_o(sat_left_idx_o), .right_idx_o(sat_right_idx_o), .span_o(sat_span_o),
    .data_val_o(sat_data_val_o), .err_o(sat_err_o),
    .word_cnt_o(sat_word_cnt_o), .err_cnt_o(sat_err_cnt_o)
  );

  typedef struct packed {
    logic [3:0] li;
    logic [3:0] ri;
    logic [4:0] span;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic exp_t ref_word(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    int   li;
    int   ri;
    e  = '0;
    li = -1;
    ri = -1;
    if (l == 16'h0 && r == 16'h0) return e;
    for (int i = 0; i < 16; i++) begin
      if (l[i]) li = i;
      if (r[i]) ri = i;
    end
    if ($countones(l) != 1 || $countones(r) != 1 || li < ri) begin
      e.err = 1'b1;
      return e;
    end
    e.li   = li[3:0];
    e.ri   = ri[3:0];
    e.span = 5'(li - ri + 1);
    return e;
  endfunction

  function automatic logic ref_err(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    e = ref_word(l, r);
    return e.err;
  endfunction

  // Cycle model of the valid pipeline and both counter widths.
  logic pv1, pe1, ov;
  int   wc, ec, wc4, ec4;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pv1 <= 1'b0; pe1 <= 1'b0; ov <= 1'b0;
      wc <= 0; ec <= 0; wc4 <= 0; ec4 <= 0;
    end else begin
      pv1 <= data_val_i;
      pe1 <= data_val_i ? ref_err(data_left_i, data_right_i) : 1'b0;
      ov  <= pv1;
      if (clr_cnt_i) begin
        wc <= 0; ec <= 0; wc4 <= 0; ec4 <= 0;
      end else if (pv1) begin
        wc  <= (wc == 65535) ? wc : wc + 1;
        wc4 <= (wc4 == 15) ? wc4 : wc4 + 1;
        if (pe1) begin
          ec  <= (ec == 65535) ? ec : ec + 1;
          ec4 <= (ec4 == 15) ? ec4 : ec4 + 1;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_n_i) begin
      chk("data_val", data_val_o, ov);
      if (data_val_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("word: left_idx=%0d right_idx=%0d span=%0d err=%0d wc=%0d ec=%0d",
                   left_idx_o, right_idx_o, span_o, err_o, word_cnt_o, err_cnt_o);
          chk("left_idx", left_idx_o, e.li);
          chk("right_idx", right_idx_o, e.ri);
          chk("span", span_o, e.span);
          chk("err", err_o, e.err);
        end
        chk("word_cnt", word_cnt_o, wc);
        chk("err_cnt", err_cnt_o, ec);
        chk("sat_word_cnt", sat_word_cnt_o, wc4);
        chk("sat_err_cnt", sat_err_cnt_o, ec4);
      end
    end
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk_i);
    data_left_i  = l;
    data_right_i = r;
    data_val_i   = 1'b1;
    exp_q.push_back(ref_word(l, r));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      data_val_i   = 1'b0;
      data_left_i  = 16'($urandom);
      data_right_i = 16'($urandom);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_left_idx"}, left_idx_o, 0);
    chk({tag, "_right_idx"}, right_idx_o, 0);
    chk({tag, "_span"}, span_o, 0);
    chk({tag, "_val"}, data_val_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_word_cnt"}, word_cnt_o, 0);
    chk({tag, "_err_cnt"}, err_cnt_o, 0);
    chk({tag, "_sat_word_cnt"}, sat_word_cnt_o, 0);
  endtask

  initial begin
    int li;
    int ri;
    rst_n_i      = 1'b0;
    data_val_i   = 1'b0;
    clr_cnt_i    = 1'b0;
    data_left_i  = '0;
    data_right_i = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    send(16'h0800, 16'h0004);
    idle(3);
    chk("first_word_cnt", word_cnt_o, 1);

    send(16'h8000, 16'h8000);
    send(16'h8000, 16'h0001);
    send(16'h0000, 16'h0000);
    send(16'h0003, 16'h0001);
    send(16'h0000, 16'h0010);
    send(16'h0002, 16'h0020);
    idle(4);
    chk("err_cnt_after_errors", err_cnt_o, 3);
    chk("word_cnt_after_errors", word_cnt_o, 7);

    // Two words in flight when reset hits: both must vanish.
    send(16'h0100, 16'h0010);
    send(16'h0040, 16'h0040);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    data_val_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    idle(4);
    chk("post_rst_word_cnt", word_cnt_o, 0);

    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        send(16'h0000, 16'h0000);
      end else begin
        ri = $urandom_range(0, 15);
        li = $urandom_range(ri, 15);
        send(16'(1) << li, 16'(1) << ri);
      end
    end
    idle(4);
    chk("stream_word_cnt", word_cnt_o, 100);
    chk("sat_word_cnt_held", sat_word_cnt_o, 15);

    // Clear lands on the same edge that presents a word.
    send(16'h0020, 16'h0002);
    @(negedge clk_i);
    data_val_i = 1'b0;
    clr_cnt_i  = 1'b1;
    @(negedge clk_i);
    clr_cnt_i = 1'b0;
    chk("clr_word_cnt", word_cnt_o, 0);
    chk("clr_err_cnt", err_cnt_o, 0);
    chk("clr_sat_word_cnt", sat_word_cnt_o, 0);
    send(16'h0004, 16'h0004);
    idle(3);
    chk("after_clr_word_cnt", word_cnt_o, 1);

    idle(2);
    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
